apb_core_master: RTL and testbench

Core-side APB master bridge for a vmicro16 core. Converts the core's single-outstanding load/store request into a two-phase APB transfer (SETUP, ACCESS) on one master port of the cluster APB interconnect. Holds the transfer stable across arbitration and slave wait states, returns read data with a one-cycle acknowledge, and aborts with an error flag if no PREADY arrives within a bounded window.

---
 rtl/apb_core_master_if.sv | 24 ++
 rtl/apb_core_master.sv | 90 +++++++++
 tb/tb_apb_core_master.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/apb_core_master_if.sv
// APB master-port signal bundle between the core bridge and the cluster interconnect.
// The bridge drives the request side through the master modport; the interconnect uses slave.
interface apb_core_master_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
);
    logic [BUS_WIDTH-1:0]  M_PADDR;
    logic                  M_PWRITE;
    logic                  M_PSELx;
    logic                  M_PENABLE;
    logic [DATA_WIDTH-1:0] M_PWDATA;
    logic [DATA_WIDTH-1:0] M_PRDATA;
    logic                  M_PREADY;

    modport master (
        output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        input  M_PRDATA, M_PREADY
    );

    modport slave (
        input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        output M_PRDATA, M_PREADY
    );
endinterface

// File: rtl/apb_core_master.sv
// Core-side APB master bridge: one outstanding load/store becomes a SETUP/ACCESS transfer,
// completed by a one-cycle ack, or aborted with err if PREADY never arrives.
module apb_core_master #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [BUS_WIDTH-1:0]  core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_busy,
    output logic                  core_ack,
    output logic                  core_err,
    output logic [DATA_WIDTH-1:0] core_rdata,
    apb_core_master_if.master     m
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic               timeout_hit;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (core_req) state_n = SETUP;
            SETUP:   state_n = ACCESS;
            ACCESS:  if (m.M_PREADY || timeout_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode only the registered state, so PREADY/PRDATA never reach them combinationally.
    // PSEL stays up through arbitration loss; the interconnect gates PENABLE downstream.
    assign m.M_PSELx   = (state == SETUP) || (state == ACCESS);
    assign m.M_PENABLE = (state == ACCESS);
    assign core_busy   = (state != IDLE);
    assign core_ack    = (state == DONE);
    assign core_err    = core_ack & err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m.M_PADDR  <= '0;
            m.M_PWRITE <= 1'b0;
            m.M_PWDATA <= '0;
            core_rdata <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (core_req) begin
                        m.M_PADDR  <= core_addr;
                        m.M_PWRITE <= core_we;
                        m.M_PWDATA <= core_wdata;
                        cnt        <= '0;
                        err_q      <= 1'b0;
                    end
                end
                ACCESS: begin
                    // A PREADY on the last allowed cycle still completes cleanly.
                    if (m.M_PREADY) begin
                        err_q <= 1'b0;
                        if (!m.M_PWRITE) core_rdata <= m.M_PRDATA;
                    end else if (timeout_hit) begin
                        err_q      <= 1'b1;
                        core_rdata <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_core_master.sv
// Cycle-table bench for apb_core_master (TIMEOUT=4): per-cycle inputs and expected outputs,
// followed by a hand-written back-to-back throughput sequence.
module tb_apb_core_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [15:0] core_addr, core_wdata;
    logic        core_busy, core_ack, core_err;
    logic [15:0] core_rdata;

    int n_cmp = 0;
    int n_err = 0;

    apb_core_master_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) bus ();

    apb_core_master #(.BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_busy  (core_busy),
        .core_ack   (core_ack),
        .core_err   (core_err),
        .core_rdata (core_rdata),
        .m          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req, we;
        logic [15:0] addr, wdata;
        logic        rdy;
        logic [15:0] prd;
        logic        busy, ack, err;
        logic [15:0] rdata;
        logic        psel, pen;
        logic [15:0] paddr;
        logic        pwr;
        logic [15:0] pwd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic req, logic we, logic [15:0] addr, logic [15:0] wdata,
                               logic rdy, logic [15:0] prd,
                               logic busy, logic ack, logic err, logic [15:0] rdata,
                               logic psel, logic pen, logic [15:0] paddr, logic pwr, logic [15:0] pwd);
        vec_t r;
        r.rst = rst; r.req = req; r.we = we; r.addr = addr; r.wdata = wdata;
        r.rdy = rdy; r.prd = prd;
        r.busy = busy; r.ack = ack; r.err = err; r.rdata = rdata;
        r.psel = psel; r.pen = pen; r.paddr = paddr; r.pwr = pwr; r.pwd = pwd;
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t r);
        reset          = r.rst;
        core_req       = r.req;
        core_we        = r.we;
        core_addr      = r.addr;
        core_wdata     = r.wdata;
        bus.M_PREADY   = r.rdy;
        bus.M_PRDATA   = r.prd;
    endtask

    initial begin
        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        bus.M_PREADY = 1'b0; bus.M_PRDATA = '0;

        //                rst req we addr     wdata    rdy prd    | busy ack err rdata   psel pen paddr    pwr pwd
        // reset
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        // load, zero wait
        tbl.push_back(v(0, 1, 0, 16'h0012, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0012, 16'h0000, 0, 16'h0000,  1, 0, 0, 16'h0000, 1, 0, 16'h0012, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0012, 16'h0000, 1, 16'hBEEF,  1, 0, 0, 16'h0000, 1, 1, 16'h0012, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 0, 16'hBEEF, 0, 0, 16'h0012, 0, 16'h0000));
        // store, three wait states, core inputs scrambled while busy
        tbl.push_back(v(0, 1, 1, 16'h0040, 16'h1234, 0, 16'h0000,  0, 0, 0, 16'hBEEF, 0, 0, 16'h0012, 0, 16'h0000));
        tbl.push_back(v(0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 16'h0000,  1, 0, 0, 16'hBEEF, 1, 0, 16'h0040, 1, 16'h1234));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 16'h0000,  1, 0, 0, 16'hBEEF, 1, 1, 16'h0040, 1, 16'h1234));
        tbl.push_back(v(0, 0, 1, 16'hFFFF, 16'hFFFF, 1, 16'h5555,  1, 0, 0, 16'hBEEF, 1, 1, 16'h0040, 1, 16'h1234));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 0, 16'hBEEF, 0, 0, 16'h0040, 1, 16'h1234));
        // timeout: no PREADY for 4 ACCESS cycles
        tbl.push_back(v(0, 1, 0, 16'h0100, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'hBEEF, 0, 0, 16'h0040, 1, 16'h1234));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 0, 16'hBEEF, 1, 0, 16'h0100, 0, 16'h0000));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 0, 16'hBEEF, 1, 1, 16'h0100, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 1, 16'h0000, 0, 0, 16'h0100, 0, 16'h0000));
        // PREADY on the final allowed ACCESS cycle
        tbl.push_back(v(0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0100, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 0, 16'h0000, 1, 0, 16'h0200, 0, 16'h0000));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h00AA,  1, 0, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 0, 16'h00AA, 0, 0, 16'h0200, 0, 16'h0000));
        // busy ignore, then reset mid-ACCESS (with PREADY present), then a clean load
        tbl.push_back(v(0, 1, 0, 16'h0300, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h00AA, 0, 0, 16'h0200, 0, 16'h0000));
        tbl.push_back(v(0, 1, 1, 16'h0400, 16'h9999, 0, 16'h0000,  1, 0, 0, 16'h00AA, 1, 0, 16'h0300, 0, 16'h0000));
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 1, 16'hDEAD,  1, 0, 0, 16'h00AA, 1, 1, 16'h0300, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(v(0, 1, 0, 16'h0500, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 0, 16'h0000, 1, 0, 16'h0500, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hC0DE,  1, 0, 0, 16'h0000, 1, 1, 16'h0500, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 0, 16'hC0DE, 0, 0, 16'h0500, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 16'hC0DE, 0, 0, 16'h0500, 0, 16'h0000));

        // Outputs depend only on state, so checking after driving on the falling edge is safe.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            if (i > 0) begin
                chk($sformatf("v%0d busy", i),   16'(core_busy),     16'(tbl[i].busy));
                chk($sformatf("v%0d ack", i),    16'(core_ack),      16'(tbl[i].ack));
                chk($sformatf("v%0d err", i),    16'(core_err),      16'(tbl[i].err));
                chk($sformatf("v%0d rdata", i),  core_rdata,         tbl[i].rdata);
                chk($sformatf("v%0d psel", i),   16'(bus.M_PSELx),   16'(tbl[i].psel));
                chk($sformatf("v%0d penable", i),16'(bus.M_PENABLE), 16'(tbl[i].pen));
                chk($sformatf("v%0d paddr", i),  bus.M_PADDR,        tbl[i].paddr);
                chk($sformatf("v%0d pwrite", i), 16'(bus.M_PWRITE),  16'(tbl[i].pwr));
                chk($sformatf("v%0d pwdata", i), bus.M_PWDATA,       tbl[i].pwd);
            end
        end

        // Back-to-back loads with req held and a zero-wait slave: acks at cycles 3 and 7.
        begin
            int first_ack  = -1;
            int second_ack = -1;
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0600; core_wdata = 16'h0000;
            bus.M_PREADY = 1'b1; bus.M_PRDATA = 16'h7777;
            for (int n = 1; n <= 20 && second_ack < 0; n++) begin
                @(negedge clk);
                if (n == 4) chk("b2b idle busy", 16'(core_busy), 16'h0000);
                if (core_ack) begin
                    chk($sformatf("b2b rdata c%0d", n), core_rdata, 16'h7777);
                    if (first_ack < 0) first_ack = n;
                    else               second_ack = n;
                end
            end
            core_req = 1'b0; bus.M_PREADY = 1'b0;
            chk("b2b first ack cycle", 16'(first_ack), 16'd3);
            chk("b2b second ack cycle", 16'(second_ack), 16'd7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
